// File: rtl/alu_cmd_assembler.sv
// alu_cmd_assembler: gathers UART bytes into 5-byte ALU command frames
// (header/opcode, operand A big-endian, operand B big-endian) and presents
// each complete frame over a valid/ready handshake. It flags bad headers,
// inter-byte timeouts and bytes that arrive while a command is pending.
module alu_cmd_assembler #(
  parameter logic [3:0]  HDR_TAG        = 4'hA,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [3:0]  cmd_op,
  output logic [15:0] cmd_a,
  output logic [15:0] cmd_b,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_HI  = 3'd1,
    A_LO  = 3'd2,
    B_HI  = 3'd3,
    B_LO  = 3'd4,
    ISSUE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_sh_q, op_sh_d;
  logic [15:0]   a_sh_q, a_sh_d;
  logic [7:0]    b_hi_sh_q, b_hi_sh_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [3:0]    cmd_op_q, cmd_op_d;
  logic [15:0]   cmd_a_q, cmd_a_d;
  logic [15:0]   cmd_b_q, cmd_b_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          eval_hdr;

  // Next-state, shadow capture, timeout counting and registered output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_sh_d     = op_sh_q;
    a_sh_d      = a_sh_q;
    b_hi_sh_d   = b_hi_sh_q;
    cmd_op_d    = cmd_op_q;
    cmd_a_d     = cmd_a_q;
    cmd_b_d     = cmd_b_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    eval_hdr    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        eval_hdr = rx_valid;
      end
      A_HI, A_LO, B_HI, B_LO: begin
        if (rx_valid) begin
          cnt_d = '0;
          case (state_q)
            A_HI: begin
              a_sh_d[15:8] = rx_data;
              state_d      = A_LO;
            end
            A_LO: begin
              a_sh_d[7:0] = rx_data;
              state_d     = B_HI;
            end
            B_HI: begin
              b_hi_sh_d = rx_data;
              state_d   = B_LO;
            end
            default: begin
              cmd_op_d = op_sh_q;
              cmd_a_d  = a_sh_q;
              cmd_b_d  = {b_hi_sh_q, rx_data};
              state_d  = ISSUE;
            end
          endcase
        end else if (cnt_q == TO_LAST) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (cmd_ready) begin
          state_d  = IDLE;
          eval_hdr = rx_valid;
        end else if (rx_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A byte seen in IDLE, or alongside the handoff in ISSUE, is a header
    // candidate; sharing this path lets back-to-back frames skip IDLE.
    if (eval_hdr) begin
      if (rx_data[7:4] == HDR_TAG) begin
        op_sh_d = rx_data[3:0];
        state_d = A_HI;
        cnt_d   = '0;
      end else begin
        frame_err_d = 1'b1;
      end
    end

    cmd_valid_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  // State, shadow and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_sh_q     <= '0;
      a_sh_q      <= '0;
      b_hi_sh_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_a_q     <= '0;
      cmd_b_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_sh_q     <= op_sh_d;
      a_sh_q      <= a_sh_d;
      b_hi_sh_q   <= b_hi_sh_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_a_q     <= cmd_a_d;
      cmd_b_q     <= cmd_b_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_a     = cmd_a_q;
  assign cmd_b     = cmd_b_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_cmd_assembler.sv
// Scoreboard bench for alu_cmd_assembler: stimulus pushes expected commands
// and error events; a negedge monitor pops and compares on each output.
module tb_alu_cmd_assembler;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int total;
  int bad;

  logic [35:0] exp_cmd[$];
  logic [7:0]  exp_evt[$];

  alu_cmd_assembler #(
    .HDR_TAG       (4'hA),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    send(b0); idle(1);
    send(b1); idle(1);
    send(b2); idle(1);
    send(b3); idle(1);
    send(b4);
  endtask

  // Monitor: compares each handshake and each error pulse against the queues
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cmd_valid && cmd_ready) begin
          if (exp_cmd.size() == 0) chk("unexpected_cmd", {cmd_op, cmd_a, cmd_b}, 36'h0);
          else chk("cmd_fields", {cmd_op, cmd_a, cmd_b}, exp_cmd.pop_front());
        end
        if (frame_err) begin
          if (exp_evt.size() == 0) chk("unexpected_frame_err", 36'd1, 36'd0);
          else chk("frame_err_event", 36'("F"), 36'(exp_evt.pop_front()));
        end
        if (overrun) begin
          if (exp_evt.size() == 0) chk("unexpected_overrun", 36'd1, 36'd0);
          else chk("overrun_event", 36'("O"), 36'(exp_evt.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int held;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    #23;
    chk("reset_outputs", {cmd_valid, frame_err, overrun, busy}, 36'h0);
    chk("reset_fields", {cmd_op, cmd_a, cmd_b}, 36'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Basic frame, ready held high: valid for exactly one cycle
    cmd_ready = 1'b1;
    exp_cmd.push_back({4'h3, 16'h1234, 16'h0005});
    frame(8'hA3, 8'h12, 8'h34, 8'h00, 8'h05);
    chk("t1_valid_rise", {cmd_valid, busy}, 36'b11);
    idle(1);
    chk("t1_valid_fall", {cmd_valid, busy}, 36'b00);
    idle(2);

    // Backpressure with an overrun byte during the wait
    cmd_ready = 1'b0;
    exp_cmd.push_back({4'h1, 16'hFFF0, 16'h0004});
    frame(8'hA1, 8'hFF, 8'hF0, 8'h00, 8'h04);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        exp_evt.push_back("O");
        send(8'h55);
      end else begin
        idle(1);
      end
      if (cmd_valid) held++;
    end
    chk("t2_held_cycles", 36'(held), 36'd10);
    chk("t2_busy_fields", {busy, cmd_a, cmd_b}, {1'b1, 16'hFFF0, 16'h0004});
    cmd_ready = 1'b1;
    idle(1);
    chk("t2_release", {cmd_valid, busy}, 36'b00);
    idle(2);

    // Bad header in IDLE, then a good frame
    exp_evt.push_back("F");
    send(8'h37);
    chk("t3_busy_after_bad_hdr", 36'(busy), 36'd0);
    idle(2);
    exp_cmd.push_back({4'h2, 16'h0001, 16'h0002});
    frame(8'hA2, 8'h00, 8'h01, 8'h00, 8'h02);
    idle(3);

    // Timeout expiry after 8 idle cycles
    send(8'hA5); idle(1);
    send(8'h12);
    exp_evt.push_back("F");
    idle(8);
    chk("t4_timeout_state", {busy, cmd_valid}, 36'b00);
    idle(2);
    // Byte arriving in the expiry cycle is accepted
    exp_cmd.push_back({4'h5, 16'h1234, 16'h5678});
    send(8'hA5); idle(1);
    send(8'h12);
    idle(7);
    chk("t4_still_busy", 36'(busy), 36'd1);
    send(8'h34);
    chk("t4_late_byte_accepted", 36'(busy), 36'd1);
    idle(1);
    send(8'h56); idle(1);
    send(8'h78);
    idle(3);

    // Handoff and new header in the same cycle
    cmd_ready = 1'b0;
    exp_cmd.push_back({4'h9, 16'h0011, 16'h0022});
    frame(8'hA9, 8'h00, 8'h11, 8'h00, 8'h22);
    idle(2);
    cmd_ready = 1'b1;
    send(8'hA4);
    chk("t5_same_cycle", {cmd_valid, busy, overrun}, 36'b010);
    exp_cmd.push_back({4'h4, 16'h0001, 16'h0002});
    idle(1);
    send(8'h00); idle(1);
    send(8'h01); idle(1);
    send(8'h00); idle(1);
    send(8'h02);
    idle(3);

    // Asynchronous reset mid-frame
    send(8'hA6); idle(1);
    send(8'h01); idle(1);
    send(8'h02);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset_ctl", {cmd_valid, frame_err, overrun, busy}, 36'h0);
    chk("t6_async_reset_fields", {cmd_op, cmd_a, cmd_b}, 36'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    exp_cmd.push_back({4'h7, 16'h0008, 16'h0003});
    frame(8'hA7, 8'h00, 8'h08, 8'h00, 8'h03);
    idle(4);

    chk("leftover_cmds", 36'(exp_cmd.size()), 36'd0);
    chk("leftover_events", 36'(exp_evt.size()), 36'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
